bus_timer: RTL and testbench

Memory-mapped down-counting timer on the processor data bus, next to the data RAM. It decodes its own 16-byte window from the processor's data address, write data and write strobe. It drives read data back for the top-level read mux, and raises an interrupt line on expiry. It provides the periodic and one-shot time base for firmware polling and the future sensor sampling loop.

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/timer_prescaler.sv | 33 +++
 rtl/bus_timer.sv | 127 ++++++++++++
 tb/tb_bus_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for bus_timer: register offsets, CTRL layout and base address.
package timer_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h0000_2000;

  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] LOAD_OFF   = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;
  localparam logic [1:0] STATUS_OFF = 2'd3;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int IE_BIT   = 2;
  localparam int PSC_LSB  = 8;
  localparam int PSC_MSB  = 15;

  typedef struct packed {
    logic [7:0] psc;
    logic       ie;
    logic       auto_rl;
    logic       en;
  } ctrl_t;

  // Only the low 16 bits of CTRL carry state; everything else reads 0.
  function automatic ctrl_t ctrl_from_word(input logic [15:0] w);
    ctrl_t c;
    c.psc     = w[PSC_MSB:PSC_LSB];
    c.ie      = w[IE_BIT];
    c.auto_rl = w[AUTO_BIT];
    c.en      = w[EN_BIT];
    return c;
  endfunction

  function automatic logic [15:0] ctrl_to_word(input ctrl_t c);
    logic [15:0] w;
    w                  = '0;
    w[PSC_MSB:PSC_LSB] = c.psc;
    w[IE_BIT]          = c.ie;
    w[AUTO_BIT]        = c.auto_rl;
    w[EN_BIT]          = c.en;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: tick when the count equals psc_i, then wraps to 0.
// Held at 0 while disabled or cleared.
module timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       clear_i,
  input  logic [7:0] psc_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       match;

  assign match  = (cnt_q == psc_i);
  assign tick_o = enable_i && match;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear_i || !enable_i || match) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level irq.
// Define TIMER_IRQ_EN to implement CTRL.IE and drive irq_o; otherwise irq_o is tied 0.
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE,
  parameter int          XLEN      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            we_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            sel_o,
  output logic            irq_o
);

  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] load_q, load_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            done_q, done_d;

  logic [1:0] off;
  logic       ctrl_wr, load_wr, status_wr;
  logic       freeze, psc_clear;
  logic       tick, tick_eff, expire;
  ctrl_t      wr_ctrl;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign sel_o     = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign off       = addr_i[3:2];
  assign ctrl_wr   = we_i && sel_o && (off == CTRL_OFF);
  assign load_wr   = we_i && sel_o && (off == LOAD_OFF);
  assign status_wr = we_i && sel_o && (off == STATUS_OFF);

  always_comb begin
    wr_ctrl = ctrl_from_word(wdata_i[15:0]);
`ifndef TIMER_IRQ_EN
    wr_ctrl.ie = 1'b0;
`endif
  end

  // A CTRL write that drops EN stops counting on that very edge.
  assign freeze    = ctrl_wr && !wdata_i[EN_BIT];
  assign psc_clear = load_wr || freeze;
  assign tick_eff  = tick && !freeze;
  assign expire    = tick_eff && (count_q == '0);

  timer_prescaler u_psc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (ctrl_q.en),
    .clear_i  (psc_clear),
    .psc_i    (ctrl_q.psc),
    .tick_o   (tick)
  );

  // Hardware updates first; bus writes afterwards so they win collisions,
  // except that a DONE set beats a same-cycle W1C.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    done_d  = done_q;

    if (expire) begin
      if (ctrl_q.auto_rl) begin
        count_d = load_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end else if (tick_eff) begin
      count_d = count_q - 1'b1;
    end

    if (ctrl_wr) begin
      ctrl_d = wr_ctrl;
    end
    if (load_wr) begin
      load_d  = wdata_i;
      count_d = wdata_i;
    end
    if (status_wr && wdata_i[0]) begin
      done_d = 1'b0;
    end
    if (expire) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel_o) begin
      case (off)
        CTRL_OFF:   rdata_o = XLEN'(ctrl_to_word(ctrl_q));
        LOAD_OFF:   rdata_o = load_q;
        COUNT_OFF:  rdata_o = count_q;
        STATUS_OFF: rdata_o = XLEN'(done_q);
        default:    rdata_o = '0;
      endcase
    end
  end

`ifdef TIMER_IRQ_EN
  assign irq_o = done_q && ctrl_q.ie;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: reset, one-shot, auto-reload, collision, decode, mid-count reset.
module tb_bus_timer;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  logic [31:0] rdata_o;
  logic        sel_o;
  logic        irq_o;

  int checks   = 0;
  int failures = 0;

`ifdef TIMER_IRQ_EN
  localparam logic IE_IMPL = 1'b1;
`else
  localparam logic IE_IMPL = 1'b0;
`endif

  bus_timer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .we_i    (we_i),
    .rdata_o (rdata_o),
    .sel_o   (sel_o),
    .irq_o   (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    we_i   = 1'b0;
    #1;
    check(tag, rdata_o, exp);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    @(negedge clk_i);
    we_i    = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    we_i    = 1'b0;

    // Reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_rd("rst_ctrl",   32'h2000, 32'h0);
    chk_rd("rst_load",   32'h2004, 32'h0);
    chk_rd("rst_count",  32'h2008, 32'h0);
    chk_rd("rst_status", 32'h200C, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_sel", {31'b0, sel_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // One-shot, PSC=0
    bus_wr(32'h2004, 32'd3);
    chk_rd("os_load", 32'h2004, 32'd3);
    bus_wr(32'h2000, 32'h5);
    chk_rd("os_cnt_en_edge", 32'h2008, 32'd3);
    @(negedge clk_i);
    chk_rd("os_cnt2", 32'h2008, 32'd2);
    @(negedge clk_i);
    chk_rd("os_cnt1", 32'h2008, 32'd1);
    @(negedge clk_i);
    chk_rd("os_cnt0", 32'h2008, 32'd0);
    chk_rd("os_done_pre", 32'h200C, 32'd0);
    check("os_irq_pre", {31'b0, irq_o}, 32'h0);
    @(negedge clk_i);
    chk_rd("os_done", 32'h200C, 32'd1);
    chk_rd("os_ctrl_en_clr", 32'h2000, IE_IMPL ? 32'h4 : 32'h0);
    chk_rd("os_cnt_hold", 32'h2008, 32'd0);
    check("os_irq", {31'b0, irq_o}, {31'b0, IE_IMPL});
    @(negedge clk_i);
    check("os_irq_hold", {31'b0, irq_o}, {31'b0, IE_IMPL});
    chk_rd("os_cnt_hold2", 32'h2008, 32'd0);
    bus_wr(32'h200C, 32'h0);
    chk_rd("os_w0_noeffect", 32'h200C, 32'd1);
    bus_wr(32'h200C, 32'h1);
    chk_rd("os_w1c", 32'h200C, 32'd0);
    check("os_irq_clr", {31'b0, irq_o}, 32'h0);

    // Auto-reload, PSC=2, LOAD=2: 9-cycle period
    bus_wr(32'h2004, 32'd2);
    bus_wr(32'h2000, 32'h0203);
    for (int i = 0; i < 9; i++) begin
      chk_rd($sformatf("ar_cnt_%0d", i), 32'h2008, 32'd2 - 32'(i / 3));
      chk_rd($sformatf("ar_done_%0d", i), 32'h200C, 32'd0);
      @(negedge clk_i);
    end
    chk_rd("ar_reload", 32'h2008, 32'd2);
    chk_rd("ar_done", 32'h200C, 32'd1);
    chk_rd("ar_ctrl", 32'h2000, 32'h0203);
    bus_wr(32'h200C, 32'h1);
    chk_rd("ar_done_clr", 32'h200C, 32'd0);
    repeat (7) @(negedge clk_i);
    chk_rd("ar_cnt_last", 32'h2008, 32'd0);
    chk_rd("ar_done_last", 32'h200C, 32'd0);

    // W1C on the expiry edge: set wins
    bus_wr(32'h200C, 32'h1);
    chk_rd("col_done", 32'h200C, 32'd1);
    chk_rd("col_reload", 32'h2008, 32'd2);

    // EN=0 freezes COUNT
    bus_wr(32'h2000, 32'h0);
    chk_rd("frz_cnt", 32'h2008, 32'd2);
    repeat (5) @(negedge clk_i);
    chk_rd("frz_cnt_later", 32'h2008, 32'd2);

    // Decode
    addr_i  = 32'h1004;
    wdata_i = 32'hFFFF_FFFF;
    #1;
    check("dec_sel_out", {31'b0, sel_o}, 32'h0);
    check("dec_rdata_out", rdata_o, 32'h0);
    bus_wr(32'h1004, 32'hFFFF_FFFF);
    chk_rd("dec_ctrl", 32'h2000, 32'h0);
    chk_rd("dec_load", 32'h2004, 32'd2);
    chk_rd("dec_status", 32'h200C, 32'd1);
    bus_wr(32'h2008, 32'h55);
    chk_rd("dec_count_ro", 32'h2008, 32'd2);
    chk_rd("dec_byte_lsb", 32'h2007, 32'd2);

    // Mid-count reset
    bus_wr(32'h200C, 32'h1);
    bus_wr(32'h2004, 32'd1000);
    bus_wr(32'h2000, 32'h5);
    repeat (4) @(negedge clk_i);
    chk_rd("mr_cnt_run", 32'h2008, 32'd996);
    rst_i = 1'b0;
    chk_rd("mr_cnt_rst", 32'h2008, 32'd0);
    chk_rd("mr_ctrl_rst", 32'h2000, 32'd0);
    chk_rd("mr_load_rst", 32'h2004, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (1100) @(negedge clk_i);
    chk_rd("mr_status_after", 32'h200C, 32'd0);
    chk_rd("mr_cnt_after", 32'h2008, 32'd0);
    check("mr_irq_after", {31'b0, irq_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
